// File: rtl/dtack_generator.sv
// ---------------------------------------------------------------------------
// dtack_generator
//
// Bus-cycle termination stage for a 68000-style bus. It sits behind the
// address decoder and terminates each CPU bus cycle with either a data
// acknowledge or a bus error.
//   - On-chip ROM/RAM and IO: DTACK after a fixed per-region wait count.
//   - DRAM/CAN: DTACK after the matching external acknowledge.
//   - Unmapped address, or an acknowledge that never arrives: BERR when
//     the watchdog expires.
//
// Ports
//   Clk                 in   system clock, rising edge
//   Reset_H             in   synchronous active-high reset
//   AS_L                in   CPU address strobe (active low, synchronous)
//   OnChipRomSelect_H   in   decoder select: on-chip ROM   (highest priority)
//   OnChipRamSelect_H   in   decoder select: on-chip RAM
//   IOSelect_H          in   decoder select: IO space
//   DramSelect_H        in   decoder select: DRAM
//   CanBusSelect_H      in   decoder select: CAN controller (lowest priority)
//   DramDtack_L         in   acknowledge from the DRAM controller
//   CanBusDtack_L       in   acknowledge from the CAN controller
//   DtackOut_L          out  registered data acknowledge to the CPU
//   BErr_L              out  registered bus error to the CPU
//   CycleActive_H       out  high while the FSM is outside IDLE
// ---------------------------------------------------------------------------
module dtack_generator #(
    parameter int ROM_WAIT       = 0,
    parameter int RAM_WAIT       = 1,
    parameter int IO_WAIT        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic Clk,
    input  logic Reset_H,
    input  logic AS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic IOSelect_H,
    input  logic DramSelect_H,
    input  logic CanBusSelect_H,
    input  logic DramDtack_L,
    input  logic CanBusDtack_L,
    output logic DtackOut_L,
    output logic BErr_L,
    output logic CycleActive_H
);

    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    // The watchdog holds k after edge E0+k, so the edge that moves it from
    // TIMEOUT_CYCLES-1 to TIMEOUT_CYCLES is the timeout edge.
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
    localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        BERR
    } state_t;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_IO,
        REG_DRAM,
        REG_CAN,
        REG_NONE
    } region_t;

    state_t           stateReg;
    region_t          regionReg;
    logic [7:0]       waitCountReg;
    logic [WDW-1:0]   watchdogReg;
    logic             dramAckReg;
    logic             canAckReg;

    region_t          selRegion;
    logic [7:0]       selWait;
    logic             selInternal;
    logic             internalRegion;
    logic             extAckSeen;

    // Priority encode the decoder selects into the region latched at E0.
    always_comb begin
        selRegion = REG_NONE;
        selWait   = 8'd0;
        if (OnChipRomSelect_H) begin
            selRegion = REG_ROM;
            selWait   = 8'(ROM_WAIT);
        end else if (OnChipRamSelect_H) begin
            selRegion = REG_RAM;
            selWait   = 8'(RAM_WAIT);
        end else if (IOSelect_H) begin
            selRegion = REG_IO;
            selWait   = 8'(IO_WAIT);
        end else if (DramSelect_H) begin
            selRegion = REG_DRAM;
        end else if (CanBusSelect_H) begin
            selRegion = REG_CAN;
        end
    end

    assign selInternal    = OnChipRomSelect_H | OnChipRamSelect_H | IOSelect_H;
    assign internalRegion = (regionReg == REG_ROM) || (regionReg == REG_RAM) ||
                            (regionReg == REG_IO);

    // External acknowledges pass through one register stage, so an
    // acknowledge sampled low at edge E terminates the cycle at edge E+1.
    // Only the acknowledge belonging to the latched region is honoured.
    assign extAckSeen = ((regionReg == REG_DRAM) && !dramAckReg) ||
                        ((regionReg == REG_CAN)  && !canAckReg);

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            stateReg      <= IDLE;
            regionReg     <= REG_NONE;
            waitCountReg  <= 8'd0;
            watchdogReg   <= '0;
            dramAckReg    <= 1'b1;
            canAckReg     <= 1'b1;
            DtackOut_L    <= 1'b1;
            BErr_L        <= 1'b1;
            CycleActive_H <= 1'b0;
        end else begin
            dramAckReg <= DramDtack_L;
            canAckReg  <= CanBusDtack_L;

            case (stateReg)
                IDLE: begin
                    if (!AS_L) begin
                        regionReg     <= selRegion;
                        waitCountReg  <= selWait;
                        watchdogReg   <= '0;
                        CycleActive_H <= 1'b1;
                        // A zero-wait internal region acknowledges on E0 itself.
                        if (selInternal && (selWait == 8'd0)) begin
                            stateReg   <= ACK;
                            DtackOut_L <= 1'b0;
                        end else begin
                            stateReg <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (waitCountReg != 8'd0) begin
                        waitCountReg <= waitCountReg - 8'd1;
                    end
                    if (watchdogReg != WD_MAX) begin
                        watchdogReg <= watchdogReg + WDW'(1);
                    end

                    if (AS_L) begin
                        // CPU abandoned the cycle: no DTACK, no BERR.
                        stateReg      <= IDLE;
                        CycleActive_H <= 1'b0;
                    end else if (extAckSeen ||
                                 (internalRegion && (waitCountReg <= 8'd1))) begin
                        // Acknowledge is checked before the watchdog so that
                        // a coincident acknowledge wins over the timeout.
                        stateReg   <= ACK;
                        DtackOut_L <= 1'b0;
                    end else if (watchdogReg == WD_LAST) begin
                        stateReg <= BERR;
                        BErr_L   <= 1'b0;
                    end
                end

                ACK: begin
                    if (AS_L) begin
                        stateReg      <= IDLE;
                        DtackOut_L    <= 1'b1;
                        CycleActive_H <= 1'b0;
                    end
                end

                BERR: begin
                    if (AS_L) begin
                        stateReg      <= IDLE;
                        BErr_L        <= 1'b1;
                        CycleActive_H <= 1'b0;
                    end
                end

                default: begin
                    stateReg      <= IDLE;
                    DtackOut_L    <= 1'b1;
                    BErr_L        <= 1'b1;
                    CycleActive_H <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtack_generator.sv
// ---------------------------------------------------------------------------
// tb_dtack_generator
//
// Directed and randomized bus cycles against dtack_generator. Expected
// outputs come from a transaction-level model: for each cycle it computes
// the edge (relative to E0) at which DTACK or BERR should assert, and the
// per-edge expectations follow from that edge and the release edge.
// ---------------------------------------------------------------------------
module tb_dtack_generator;

    localparam int ROM_W = 0;
    localparam int RAM_W = 1;
    localparam int IO_W  = 2;
    localparam int T     = 16;

    logic Clk = 1'b0;
    logic Reset_H;
    logic AS_L;
    logic OnChipRomSelect_H;
    logic OnChipRamSelect_H;
    logic IOSelect_H;
    logic DramSelect_H;
    logic CanBusSelect_H;
    logic DramDtack_L;
    logic CanBusDtack_L;
    logic DtackOut_L;
    logic BErr_L;
    logic CycleActive_H;

    int compared   = 0;
    int mismatched = 0;

    dtack_generator #(
        .ROM_WAIT      (ROM_W),
        .RAM_WAIT      (RAM_W),
        .IO_WAIT       (IO_W),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .Clk              (Clk),
        .Reset_H          (Reset_H),
        .AS_L             (AS_L),
        .OnChipRomSelect_H(OnChipRomSelect_H),
        .OnChipRamSelect_H(OnChipRamSelect_H),
        .IOSelect_H       (IOSelect_H),
        .DramSelect_H     (DramSelect_H),
        .CanBusSelect_H   (CanBusSelect_H),
        .DramDtack_L      (DramDtack_L),
        .CanBusDtack_L    (CanBusDtack_L),
        .DtackOut_L       (DtackOut_L),
        .BErr_L           (BErr_L),
        .CycleActive_H    (CycleActive_H)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic expD, input logic expB,
                            input logic expA);
        check({tag, " dtack"},  DtackOut_L,    expD);
        check({tag, " berr"},   BErr_L,        expB);
        check({tag, " active"}, CycleActive_H, expA);
    endtask

    task automatic driveSel(input logic [4:0] s);
        {CanBusSelect_H, DramSelect_H, IOSelect_H, OnChipRamSelect_H,
         OnChipRomSelect_H} = s;
    endtask

    // Advance one rising edge and settle before sampling outputs.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Transaction-level reference: sel bit0=ROM .. bit4=CAN, lowest bit wins.
    // ackAt = edge index (from E0) at which the region's acknowledge is
    // sampled low, or -1 for none. Returns whether the cycle ends in DTACK
    // and the edge index after which the terminating output is low.
    function automatic void predict(input logic [4:0] sel, input int ackAt,
                                    output bit isAck, output int ev);
        int cand;
        isAck = 1'b0;
        ev    = T;
        if (sel[0]) begin
            isAck = 1'b1; ev = ROM_W;
        end else if (sel[1]) begin
            isAck = 1'b1; ev = RAM_W;
        end else if (sel[2]) begin
            isAck = 1'b1; ev = IO_W;
        end else if (sel[3] || sel[4]) begin
            cand = (ackAt >= 0) ? ackAt + 1 : 1000000;
            if (cand <= T) begin
                isAck = 1'b1; ev = cand;
            end
        end
    endfunction

    // One bus cycle. AS_L low for edges E0..E0+rel-1, sampled high at E0+rel.
    // otherAt pulses the acknowledge that does not belong to the region.
    task automatic runTxn(input string tag, input logic [4:0] sel, input int ackAt,
                          input int otherAt, input int rel);
        bit   isAck;
        int   ev;
        bit   onCan;
        logic m;
        logic o;
        logic expD;
        logic expB;
        logic expA;
        int   startMis;
        predict(sel, ackAt, isAck, ev);
        onCan    = (sel[3:0] == 4'b0000) && sel[4];
        startMis = mismatched;
        for (int k = 0; k <= rel; k++) begin
            AS_L = (k == rel);
            if (k == 0) driveSel(sel);
            else        driveSel(5'($urandom));
            m = (k == ackAt)   ? 1'b0 : 1'b1;
            o = (k == otherAt) ? 1'b0 : 1'b1;
            if (onCan) {CanBusDtack_L, DramDtack_L} = {m, o};
            else       {DramDtack_L, CanBusDtack_L} = {m, o};
            tick();
            if (k == rel) begin
                expD = 1'b1; expB = 1'b1; expA = 1'b0;
            end else begin
                expD = !(isAck && (k >= ev));
                expB = !(!isAck && (k >= ev));
                expA = 1'b1;
            end
            checkAll($sformatf("%s k=%0d", tag, k), expD, expB, expA);
        end
        // Mandatory idle edge between cycles.
        AS_L          = 1'b1;
        DramDtack_L   = 1'b1;
        CanBusDtack_L = 1'b1;
        driveSel(5'($urandom));
        tick();
        checkAll({tag, " gap"}, 1'b1, 1'b1, 1'b0);
        $display("txn %-14s sel=%b ackAt=%0d otherAt=%0d rel=%0d -> %s@E0+%0d %s",
                 tag, sel, ackAt, otherAt, rel, isAck ? "DTACK" : "BERR", ev,
                 (rel <= ev) ? "(aborted)" : "",
                 (mismatched == startMis) ? "ok" : "errors");
    endtask

    initial begin
        bit   isAck;
        int   ev;
        int   rel;
        int   ackAt;
        logic [4:0] sel;

        Reset_H       = 1'b1;
        AS_L          = 1'b1;
        DramDtack_L   = 1'b1;
        CanBusDtack_L = 1'b1;
        driveSel(5'b00000);
        tick();
        tick();
        checkAll("reset", 1'b1, 1'b1, 1'b0);
        Reset_H = 1'b0;
        tick();
        checkAll("idle", 1'b1, 1'b1, 1'b0);

        // Directed cycles.
        runTxn("rom_w0",      5'b00001, -1, -1, 4);
        runTxn("ram_w1",      5'b00010, -1, -1, 3);
        runTxn("io_w2",       5'b00100, -1, -1, 5);
        runTxn("prio_all",    5'b11111, -1, -1, 2);
        runTxn("prio_ram",    5'b11110,  0,  0, 3);
        runTxn("dram_ack5",   5'b01000,  5,  2, 8);
        runTxn("can_earliest",5'b10000,  0,  3, 3);
        runTxn("can_wrongack",5'b10000, -1,  1, 18);
        runTxn("unmapped",    5'b00000,  3,  4, 18);
        runTxn("dram_vs_wd",  5'b01000, T-1, -1, T+2);
        runTxn("dram_late",   5'b01000, T,  -1, T+2);
        runTxn("io_abort",    5'b00100, -1, -1, 1);

        // Reset in the middle of a DRAM WAIT.
        AS_L = 1'b0;
        driveSel(5'b01000);
        tick();
        checkAll("rstwait E0", 1'b1, 1'b1, 1'b1);
        tick();
        Reset_H = 1'b1;
        tick();
        checkAll("rstwait hit", 1'b1, 1'b1, 1'b0);
        Reset_H = 1'b0;
        // AS_L still low: the next edge is E0 of a new cycle.
        runTxn("post_rst_io", 5'b00100, -1, -1, 4);

        // Reset while in BERR.
        AS_L = 1'b0;
        driveSel(5'b00000);
        for (int k = 0; k <= T; k++) tick();
        checkAll("rstberr pre", 1'b1, 1'b0, 1'b1);
        Reset_H = 1'b1;
        tick();
        checkAll("rstberr hit", 1'b1, 1'b1, 1'b0);
        Reset_H = 1'b0;
        AS_L    = 1'b1;
        tick();
        checkAll("rstberr idle", 1'b1, 1'b1, 1'b0);

        // Randomized cycles.
        for (int n = 0; n < 40; n++) begin
            sel   = ($urandom_range(0, 3) == 0) ? 5'b00000 : 5'($urandom);
            ackAt = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, T + 2));
            predict(sel, ackAt, isAck, ev);
            if ((ev >= 2) && ($urandom_range(0, 4) == 0))
                rel = int'($urandom_range(1, ev - 1));
            else
                rel = ev + 1 + int'($urandom_range(0, 3));
            runTxn($sformatf("rand%0d", n), sel, ackAt,
                   int'($urandom_range(0, T + 2)), rel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
